yutorina_gpr_wb: RTL and testbench
==================================

Name: yutorina_gpr_wb

Overview:
- Write-back stage that produces the single GPR write port (we_, w_addr, w_data).
- Merges two result sources:
  - Execute-stage results, which cannot stall.
  - Out-of-order-latency load responses, which return in issue order.
- Keeps an in-order tag FIFO of pending load destinations, and reports register hazards to decode so dependent instructions interlock.

Parameters:
LD_DEPTH, 4, pending-load tag FIFO depth (power of two, >=2)
GPR_ADDR_W, 5, GPR address width (`GPR_ADDR_W)
WORD_W, 32, data width (`WORD_DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  pipeline flush; kills the execute result and load issue this cycle
ex_we_  in  1  execute result write enable, active-low (`ENABLE_ = 0)
ex_dst  in  GPR_ADDR_W  execute destination register
ex_data  in  WORD_W  execute result
ld_issue  in  1  load issued this cycle, active-high
ld_dst  in  GPR_ADDR_W  destination register of the issued load
ld_issue_rdy  out  1  tag FIFO not full
ld_rsp_valid  in  1  load data valid
ld_rsp_data  in  WORD_W  load data
ld_rsp_rdy  out  1  load response accepted when high with ld_rsp_valid
id_rs1  in  GPR_ADDR_W  decode source 1
id_rs2  in  GPR_ADDR_W  decode source 2
id_rd  in  GPR_ADDR_W  decode destination
id_hazard  out  1  decode must stall
we_  out  1  GPR write enable, active-low
w_addr  out  GPR_ADDR_W  GPR write address
w_data  out  WORD_W  GPR write data

Behaviour:
Reset:
- Asynchronous on rst high.
- Outputs: we_ = 1 (`DISABLE_), w_addr = 0, w_data = 0.
- Tag FIFO empty, skid register empty.
- ld_issue_rdy = 1, ld_rsp_rdy = 0.

Tag FIFO:
- Push: ld_issue && ld_issue_rdy && !flush; pushes ld_dst.
- ld_issue while full is ignored; issuers must honour ld_issue_rdy.
- Pop: an accepted load response pops the head.
- Push and pop in the same cycle are both legal, including when the FIFO is full (count unchanged).
- Pointers wrap modulo LD_DEPTH.
- Occupancy counter is LD_DEPTH+1 wide in value (0..LD_DEPTH).

Skid register:
- One entry {valid, addr, data}.
- ld_rsp_rdy = fifo_not_empty && (!skid_valid || skid_drains_this_cycle).
- Accepted response: skid <= {1, fifo_head, ld_rsp_data} at the next edge.
- ld_rsp_valid with an empty FIFO is a protocol error: not accepted, no state change.

Write arbitration (registered outputs, one write per cycle):
- Execute wins: ex_we_ == 0 && !flush → next we_ = 0, w_addr = ex_dst, w_data = ex_data.
- Else skid_valid → next write is the skid entry; skid_drains_this_cycle = 1.
- Else next we_ = 1; w_addr/w_data hold their last values.
- Latency:
  - Execute result appears on the port 1 cycle after input.
  - Load data: 1 cycle after acceptance (skid), then ≥1 cycle to the port.
- Writes to register 0 (`GPR_ZERO):
  - Never assert we_; the slot is consumed silently.
  - A skid entry addressed to r0 still drains.

Hazard (combinational):
- busy(r) = (r != 0) && (r matches any valid tag FIFO entry, or the valid skid entry, or the registered output write address while we_ == 0 for a load-sourced write).
- The registered-output case is covered by the GPR bypass, so exclude it from busy.
- id_hazard = busy(id_rs1) | busy(id_rs2) | busy(id_rd). The id_rd term prevents a WAW overtaking a pending load.

Simultaneous events and boundary conditions:
- ld_issue and response pop in the same cycle, same register: busy remains set (the new entry matches).
- flush does not cancel loads already in the FIFO or skid; they complete and write.
- A load issued in the same cycle as flush is ignored.

Decomposition:
- Shared header gpr.h/stddef.h: GPR_ADDR_W, GPR_NUM, GPR_ZERO, WORD_DATA_W, ENABLE_/DISABLE_, RESET_EDGE/RESET_ENABLE.
- New header gpr_wb.h: LD_DEPTH default and pointer width.
- One sub-module, yutorina_ld_tag_fifo:
  - Parameterized register-array FIFO.
  - Outputs head, full, empty, and a per-entry valid/addr vector used by the hazard compare.

Test Plan:
- Reset mid-traffic (FIFO holding 2 tags, skid valid) → next cycle we_=1, w_addr=0, w_data=0, ld_issue_rdy=1, ld_rsp_rdy=0, id_hazard=0.
- ex_we_=0, ex_dst=5, ex_data=0x12345678 → one cycle later we_=0, w_addr=5, w_data=0x12345678; the same stimulus with flush=1 → we_ stays 1.
- ld_issue ld_dst=7; id_rs1=7 → id_hazard=1 until the response (0xCAFEF00D) is drained to the port; then w_addr=7, w_data=0xCAFEF00D and id_hazard=0.
- Load response accepted while execute writes every cycle → skid holds, ld_rsp_rdy=0 for the next response; the skid write appears the first cycle ex_we_=1; no data lost, order preserved.
- Issue LD_DEPTH=4 loads (dst 1,2,3,4) → ld_issue_rdy=0; a 5th ld_issue is ignored; a response pop with a simultaneous issue keeps the count at 4; responses write r1..r4 in order.
- Load to r0 and ex_dst=0 → we_ never asserted, id_hazard with id_rs1=0 stays 0, the FIFO entry still pops.

Source files
------------

// File: rtl/yutorina_gpr_wb_pkg.sv
// ---------------------------------------------------------------------------
// yutorina_gpr_wb_pkg
//   Shared constants for the GPR write-back slice: register-file geometry,
//   active-low enable encoding, reset level, default pending-load depth and
//   the write-source selector used by the write-port arbiter.
// ---------------------------------------------------------------------------
package yutorina_gpr_wb_pkg;

  // Register file geometry (r0 is hard-wired zero and never written).
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int WORD_DATA_W    = 32;

  // Write enables in this pipeline are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Reset is asynchronous and active-high.
  localparam logic RESET_ENABLE = 1'b1;

  // Default number of loads that may be in flight at once.
  localparam int LD_DEPTH_DEFAULT = 4;

  // Which source owns the write port in a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_EX   = 2'd1,
    WB_SRC_LD   = 2'd2
  } wb_src_e;

  // Pointer width for a power-of-two FIFO; at least one bit.
  function automatic int ld_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/yutorina_ld_tag_fifo.sv
// ---------------------------------------------------------------------------
// yutorina_ld_tag_fifo
//   In-order FIFO of destination registers for loads that have been issued
//   but whose data has not yet been accepted. Loads return in issue order,
//   so the head is always the destination of the next response.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_addr  enqueue a destination (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop              dequeue the head (ignored when empty)
//   head             destination at the head of the queue
//   full, empty      occupancy flags
//   ent_valid        per-slot occupancy, indexed by physical slot
//   ent_addr         per-slot destination, indexed by physical slot
// ---------------------------------------------------------------------------
module yutorina_ld_tag_fifo
  import yutorina_gpr_wb_pkg::*;
#(
  parameter int DEPTH = LD_DEPTH_DEFAULT,
  parameter int AW    = GPR_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [AW-1:0]             push_addr,
  input  logic                      pop,
  output logic [AW-1:0]             head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr
);

  localparam int PTR_W = ld_ptr_w(DEPTH);
  // Occupancy spans 0..DEPTH inclusive.
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DEPTH-1:0][AW-1:0]  mem_q, mem_d;
  logic                      pop_ok;
  logic                      push_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    pop_ok  = pop && !empty;
    // When full, the slot being popped is the one the write pointer points
    // at, so a simultaneous push simply reuses it.
    push_ok = push && (!full || pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_addr;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // wraps: DEPTH is a power of two
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Slot i is live when its distance from the read pointer is below the
  // occupancy count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q);
    end
    ent_addr = mem_q;
    head     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/yutorina_gpr_wb.sv
// ---------------------------------------------------------------------------
// yutorina_gpr_wb
//   Write-back stage driving the single GPR write port. Execute results
//   (which cannot stall) always win the port; load responses, which return
//   in issue order, are captured in a one-entry skid register and written
//   in the first cycle execute leaves the port free. A tag FIFO remembers
//   pending load destinations so decode can interlock on them.
//
// Handshakes: ld_rsp_valid/ld_rsp_rdy is a valid/ready pair; a response is
//   transferred in any cycle where both are high, and ld_rsp_rdy never
//   depends on ld_rsp_valid. ld_issue is transferred when ld_issue &&
//   ld_issue_rdy && !flush; issuers must hold off while ld_issue_rdy is low.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kills this cycle's execute result and load issue
//   ex_we_, ex_dst, ex_data   execute result (active-low enable)
//   ld_issue, ld_dst          load issue and its destination
//   ld_issue_rdy              a load issue can be accepted this cycle
//   ld_rsp_valid, ld_rsp_data load response
//   ld_rsp_rdy                load response accepted this cycle if valid
//   id_rs1, id_rs2, id_rd     decode register operands
//   id_hazard                 decode must stall
//   we_, w_addr, w_data       registered GPR write port (active-low enable)
// ---------------------------------------------------------------------------
module yutorina_gpr_wb
  import yutorina_gpr_wb_pkg::*;
#(
  parameter int LD_DEPTH   = LD_DEPTH_DEFAULT,
  parameter int GPR_ADDR_W = GPR_ADDR_WIDTH,
  parameter int WORD_W     = WORD_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_we_,
  input  logic [GPR_ADDR_W-1:0] ex_dst,
  input  logic [WORD_W-1:0]     ex_data,
  input  logic                  ld_issue,
  input  logic [GPR_ADDR_W-1:0] ld_dst,
  output logic                  ld_issue_rdy,
  input  logic                  ld_rsp_valid,
  input  logic [WORD_W-1:0]     ld_rsp_data,
  output logic                  ld_rsp_rdy,
  input  logic [GPR_ADDR_W-1:0] id_rs1,
  input  logic [GPR_ADDR_W-1:0] id_rs2,
  input  logic [GPR_ADDR_W-1:0] id_rd,
  output logic                  id_hazard,
  output logic                  we_,
  output logic [GPR_ADDR_W-1:0] w_addr,
  output logic [WORD_W-1:0]     w_data
);

  // Tag FIFO interface
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [GPR_ADDR_W-1:0]               fifo_head;
  logic [LD_DEPTH-1:0]                 ent_valid;
  logic [LD_DEPTH-1:0][GPR_ADDR_W-1:0] ent_addr;

  // Handshake decode
  logic ex_win;
  logic skid_drain;
  logic rsp_accept;
  logic issue_push;

  // Skid register
  logic                  skid_valid_q, skid_valid_d;
  logic [GPR_ADDR_W-1:0] skid_addr_q,  skid_addr_d;
  logic [WORD_W-1:0]     skid_data_q,  skid_data_d;

  // Registered write port
  logic                  we_q,     we_d;
  logic [GPR_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [WORD_W-1:0]     w_data_q, w_data_d;

  wb_src_e wb_src;

  // Hazard terms
  logic busy_rs1;
  logic busy_rs2;
  logic busy_rd;

  yutorina_ld_tag_fifo #(
    .DEPTH (LD_DEPTH),
    .AW    (GPR_ADDR_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_push),
    .push_addr (ld_dst),
    .pop       (rsp_accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    // Execute owns the port whenever it has a live result, even for r0.
    ex_win     = (ex_we_ == ENABLE_) && !flush;
    skid_drain = skid_valid_q && !ex_win;
    // A response may enter the skid only if the skid is free at the edge.
    ld_rsp_rdy = !fifo_empty && (!skid_valid_q || skid_drain);
    rsp_accept = ld_rsp_valid && ld_rsp_rdy;
    // A full FIFO still takes an issue when the head pops in the same cycle.
    ld_issue_rdy = !fifo_full || rsp_accept;
    issue_push   = ld_issue && ld_issue_rdy && !flush;
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    if (rsp_accept) begin
      skid_valid_d = 1'b1;
      skid_addr_d  = fifo_head;
      skid_data_d  = ld_rsp_data;
    end else if (skid_drain) begin
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    if (ex_win) begin
      wb_src = WB_SRC_EX;
    end else if (skid_valid_q) begin
      wb_src = WB_SRC_LD;
    end else begin
      wb_src = WB_SRC_NONE;
    end

    // Address/data hold when no write is produced; a write aimed at r0
    // consumes its slot without touching the port.
    we_d     = DISABLE_;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    case (wb_src)
      WB_SRC_EX: begin
        if (ex_dst != '0) begin
          we_d     = ENABLE_;
          w_addr_d = ex_dst;
          w_data_d = ex_data;
        end
      end
      WB_SRC_LD: begin
        if (skid_addr_q != '0) begin
          we_d     = ENABLE_;
          w_addr_d = skid_addr_q;
          w_data_d = skid_data_q;
        end
      end
      default: begin
        we_d = DISABLE_;
      end
    endcase
  end

  // A register is busy while a load targeting it sits in the tag FIFO or the
  // skid. Once on the write port the GPR bypass forwards it, so the output
  // register is deliberately not part of the compare. r0 is never busy.
  always_comb begin
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    busy_rd  = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (ent_addr[i] == id_rs1) busy_rs1 = 1'b1;
        if (ent_addr[i] == id_rs2) busy_rs2 = 1'b1;
        if (ent_addr[i] == id_rd)  busy_rd  = 1'b1;
      end
    end
    if (skid_valid_q) begin
      if (skid_addr_q == id_rs1) busy_rs1 = 1'b1;
      if (skid_addr_q == id_rs2) busy_rs2 = 1'b1;
      if (skid_addr_q == id_rd)  busy_rd  = 1'b1;
    end
    // The id_rd term stops a younger write overtaking a pending load (WAW).
    id_hazard = (busy_rs1 && (id_rs1 != '0)) ||
                (busy_rs2 && (id_rs2 != '0)) ||
                (busy_rd  && (id_rd  != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ENABLE) begin
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      we_q         <= DISABLE_;
      w_addr_q     <= '0;
      w_data_q     <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      we_q         <= we_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  assign we_    = we_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule

// File: tb/tb_yutorina_gpr_wb.sv
module tb_yutorina_gpr_wb;

  localparam int LD_DEPTH = 4;
  localparam int AW       = 5;
  localparam int DW       = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush;
  logic          ex_we_;
  logic [AW-1:0] ex_dst;
  logic [DW-1:0] ex_data;
  logic          ld_issue;
  logic [AW-1:0] ld_dst;
  logic          ld_issue_rdy;
  logic          ld_rsp_valid;
  logic [DW-1:0] ld_rsp_data;
  logic          ld_rsp_rdy;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] id_rd;
  logic          id_hazard;
  logic          we_;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  yutorina_gpr_wb #(
    .LD_DEPTH   (LD_DEPTH),
    .GPR_ADDR_W (AW),
    .WORD_W     (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_we_       (ex_we_),
    .ex_dst       (ex_dst),
    .ex_data      (ex_data),
    .ld_issue     (ld_issue),
    .ld_dst       (ld_dst),
    .ld_issue_rdy (ld_issue_rdy),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_rdy   (ld_rsp_rdy),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_hazard    (id_hazard),
    .we_          (we_),
    .w_addr       (w_addr),
    .w_data       (w_data)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending load destinations in issue order, the captured
  // response awaiting the port, and the expected write-port contents.
  logic [AW-1:0] exp_q[$];
  logic          m_skid_v;
  logic [AW-1:0] m_skid_a;
  logic [DW-1:0] m_skid_d;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic logic m_busy(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i] == r) return 1'b1;
    return m_skid_v && (m_skid_a == r);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_skid_v = 1'b0;
    m_skid_a = '0;
    m_skid_d = '0;
    m_we     = 1'b1;
    m_addr   = '0;
    m_data   = '0;
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle();
    flush        = 1'b0;
    ex_we_       = 1'b1;
    ex_dst       = '0;
    ex_data      = '0;
    ld_issue     = 1'b0;
    ld_dst       = '0;
    ld_rsp_valid = 1'b0;
    ld_rsp_data  = '0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_rd        = '0;
  endtask

  // Called just after a falling edge with inputs already driven: compares
  // every output against the model, advances the model, then runs one clock.
  task automatic step();
    logic ex_win, drain, rsp_rdy, accept, issue_rdy, push;
    logic [AW-1:0] head;
    #1;
    ex_win    = !ex_we_ && !flush;
    drain     = m_skid_v && !ex_win;
    rsp_rdy   = (exp_q.size() > 0) && (!m_skid_v || drain);
    accept    = ld_rsp_valid && rsp_rdy;
    issue_rdy = (exp_q.size() < LD_DEPTH) || accept;
    push      = ld_issue && issue_rdy && !flush;

    chk("we_", we_, m_we);
    chk("w_addr", w_addr, m_addr);
    chk("w_data", w_data, m_data);
    chk("ld_rsp_rdy", ld_rsp_rdy, rsp_rdy);
    chk("ld_issue_rdy", ld_issue_rdy, issue_rdy);
    chk("id_hazard", id_hazard, m_busy(id_rs1) || m_busy(id_rs2) || m_busy(id_rd));

    if (ex_win) begin
      if (ex_dst != '0) begin
        m_we = 1'b0; m_addr = ex_dst; m_data = ex_data;
      end else begin
        m_we = 1'b1;
      end
    end else if (m_skid_v) begin
      if (m_skid_a != '0) begin
        m_we = 1'b0; m_addr = m_skid_a; m_data = m_skid_d;
      end else begin
        m_we = 1'b1;
      end
    end else begin
      m_we = 1'b1;
    end

    if (accept) begin
      head     = exp_q.pop_front();
      m_skid_v = 1'b1;
      m_skid_a = head;
      m_skid_d = ld_rsp_data;
    end else if (drain) begin
      m_skid_v = 1'b0;
    end
    if (push) exp_q.push_back(ld_dst);

    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle; the reset is asynchronous so outputs must clear
  // before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_we_", we_, 1'b1);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_ld_issue_rdy", ld_issue_rdy, 1'b1);
    chk("rst_ld_rsp_rdy", ld_rsp_rdy, 1'b0);
    chk("rst_id_hazard", id_hazard, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [AW-1:0] got_q[$];

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Execute write, then the same stimulus killed by flush.
    idle(); ex_we_ = 1'b0; ex_dst = 5; ex_data = 32'h1234_5678; step();
    chk("ex_we_", we_, 1'b0);
    chk("ex_w_addr", w_addr, 5);
    chk("ex_w_data", w_data, 32'h1234_5678);
    idle(); ex_we_ = 1'b0; ex_dst = 5; ex_data = 32'h1234_5678; flush = 1'b1; step();
    chk("flush_we_", we_, 1'b1);

    // Single load to r7 with decode reading r7.
    idle(); ld_issue = 1'b1; ld_dst = 7; id_rs1 = 7; step();
    idle(); id_rs1 = 7; #1;
    chk("ld7_haz_fifo", id_hazard, 1'b1);
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hCAFE_F00D; step();
    idle(); id_rs1 = 7; #1;
    chk("ld7_haz_skid", id_hazard, 1'b1);
    step();
    idle(); id_rs1 = 7; #1;
    chk("ld7_we_", we_, 1'b0);
    chk("ld7_w_addr", w_addr, 7);
    chk("ld7_w_data", w_data, 32'hCAFE_F00D);
    chk("ld7_haz_clear", id_hazard, 1'b0);
    step();

    // Skid holds while execute owns the port every cycle.
    idle(); ld_issue = 1'b1; ld_dst = 2; step();
    idle(); ld_issue = 1'b1; ld_dst = 3; step();
    idle(); ex_we_ = 1'b0; ex_dst = 10; ex_data = 32'h0000_0A0A;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hAAAA_0002; step();
    for (int k = 0; k < 2; k++) begin
      idle(); ex_we_ = 1'b0; ex_dst = AW'(11 + k); ex_data = 32'(k);
      ld_rsp_valid = 1'b1; ld_rsp_data = 32'hBBBB_0003; #1;
      chk("skid_hold_rdy", ld_rsp_rdy, 1'b0);
      step();
    end
    idle(); ld_rsp_valid = 1'b1; ld_rsp_data = 32'hBBBB_0003; #1;
    chk("skid_drain_rdy", ld_rsp_rdy, 1'b1);
    step();
    idle(); #1;
    chk("skid1_w_addr", w_addr, 2);
    chk("skid1_w_data", w_data, 32'hAAAA_0002);
    step();
    idle(); #1;
    chk("skid2_w_addr", w_addr, 3);
    chk("skid2_w_data", w_data, 32'hBBBB_0003);
    step();

    // Fill the tag FIFO, try a 5th issue, then pop+issue while full.
    for (int k = 1; k <= LD_DEPTH; k++) begin
      idle(); ld_issue = 1'b1; ld_dst = AW'(k); step();
    end
    idle(); #1;
    chk("full_issue_rdy", ld_issue_rdy, 1'b0);
    ld_issue = 1'b1; ld_dst = 9; step();
    idle(); ld_issue = 1'b1; ld_dst = 5; ld_rsp_valid = 1'b1; ld_rsp_data = 32'hD000_0001; #1;
    chk("full_pop_issue_rdy", ld_issue_rdy, 1'b1);
    step();
    idle(); #1;
    chk("full_again_issue_rdy", ld_issue_rdy, 1'b0);
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      idle(); ld_rsp_valid = 1'b1; ld_rsp_data = 32'hD000_0002 + 32'(k); step();
      if (we_ == 1'b0) got_q.push_back(w_addr);
    end
    chk("order_count", got_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size()) chk("order_addr", got_q[k], k + 1);
    end

    // r0 writes from both sources are swallowed; the r0 tag still pops.
    idle(); ld_issue = 1'b1; ld_dst = 0; ex_we_ = 1'b0; ex_dst = 0; ex_data = 32'hDEAD_BEEF; step();
    chk("r0_ex_we_", we_, 1'b1);
    idle(); ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0005; #1;
    chk("r0_haz", id_hazard, 1'b0);
    chk("r0_rsp_rdy", ld_rsp_rdy, 1'b1);
    step();
    idle(); step();
    chk("r0_ld_we_", we_, 1'b1);
    #1;
    chk("r0_popped_rsp_rdy", ld_rsp_rdy, 1'b0);

    // Reset with two tags pending and the skid occupied.
    for (int k = 0; k < 3; k++) begin
      idle(); ld_issue = 1'b1; ld_dst = AW'(8 + k); step();
    end
    idle(); ex_we_ = 1'b0; ex_dst = 1; ex_data = 32'h1; ld_rsp_valid = 1'b1; ld_rsp_data = 32'h77; step();
    idle(); ex_we_ = 1'b0; ex_dst = 1; id_rs1 = 9;
    do_reset();
    idle(); step();

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      idle();
      ex_we_       = ($urandom_range(0, 2) == 0);
      ex_dst       = AW'($urandom_range(0, 7));
      ex_data      = $urandom;
      flush        = ($urandom_range(0, 15) == 0);
      ld_issue     = $urandom_range(0, 1) == 1;
      ld_dst       = AW'($urandom_range(0, 7));
      ld_rsp_valid = $urandom_range(0, 1) == 1;
      ld_rsp_data  = $urandom;
      id_rs1       = AW'($urandom_range(0, 7));
      id_rs2       = AW'($urandom_range(0, 7));
      id_rd        = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
